// File: rtl/cnn_pkg.sv
// Shared CNN constants and the max-pool controller state type.
package cnn_pkg;

  localparam int NUM_FILT     = 16;
  localparam int CONV_OUT_DIM = 26;
  localparam int POOL_OUT_DIM = 13;
  localparam int ACC_W        = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_CONV = 2'd1,
    POOL      = 2'd2,
    DONE      = 2'd3
  } pool_state_t;

endpackage

// File: rtl/max4_unit.sv
// Combinational signed maximum of four values via a two-level compare tree.
module max4_unit #(
  parameter int DATA_W = cnn_pkg::ACC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] max_ab;
  logic signed [DATA_W-1:0] max_cd;

  assign max_ab = (b > a) ? b : a;
  assign max_cd = (d > c) ? d : c;
  assign y      = (max_cd > max_ab) ? max_cd : max_ab;

endmodule

// File: rtl/maxpool1_seq.sv
// Triggers conv1, waits for its done pulse, then 2x2/stride-2 max-pools its
// feature map one output element per cycle and holds done until start drops.
module maxpool1_seq #(
  parameter int NUM_FILT = cnn_pkg::NUM_FILT,
  parameter int IN_DIM   = cnn_pkg::CONV_OUT_DIM,
  parameter int OUT_DIM  = cnn_pkg::POOL_OUT_DIM,
  parameter int DATA_W   = cnn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     done,
  output logic                     conv_t,
  input  logic                     conv_d,
  input  logic signed [DATA_W-1:0] feat_map [NUM_FILT][IN_DIM][IN_DIM],
  output logic signed [DATA_W-1:0] pool_map [NUM_FILT][OUT_DIM][OUT_DIM]
);

  import cnn_pkg::*;

  localparam int FW = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int RW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IW = RW + 1;

  pool_state_t state;

  logic [FW-1:0] f_cnt;
  logic [RW-1:0] r_cnt;
  logic [RW-1:0] c_cnt;

  logic [IW-1:0] y0, y1, x0, x1;
  logic          last_c, last_r, last_f;

  logic signed [DATA_W-1:0] win_max;

  // Window corners: even row/column is the top-left, odd is the bottom-right.
  assign y0 = {r_cnt, 1'b0};
  assign y1 = {r_cnt, 1'b1};
  assign x0 = {c_cnt, 1'b0};
  assign x1 = {c_cnt, 1'b1};

  assign last_c = (c_cnt == RW'(OUT_DIM - 1));
  assign last_r = (r_cnt == RW'(OUT_DIM - 1));
  assign last_f = (f_cnt == FW'(NUM_FILT - 1));

  max4_unit #(.DATA_W(DATA_W)) u_max4 (
    .a (feat_map[f_cnt][y0][x0]),
    .b (feat_map[f_cnt][y0][x1]),
    .c (feat_map[f_cnt][y1][x0]),
    .d (feat_map[f_cnt][y1][x1]),
    .y (win_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      conv_t <= 1'b0;
      f_cnt  <= '0;
      r_cnt  <= '0;
      c_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            conv_t <= 1'b1;
            state  <= WAIT_CONV;
          end
        end
        WAIT_CONV: begin
          // Dropping conv_t right after conv_d lets conv1 leave its wait-low state.
          if (conv_d) begin
            conv_t <= 1'b0;
            f_cnt  <= '0;
            r_cnt  <= '0;
            c_cnt  <= '0;
            state  <= POOL;
          end
        end
        POOL: begin
          if (last_c) begin
            c_cnt <= '0;
            if (last_r) begin
              r_cnt <= '0;
              if (last_f) begin
                f_cnt <= '0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                f_cnt <= f_cnt + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          done   <= 1'b0;
          conv_t <= 1'b0;
        end
      endcase
    end
  end

  // Result storage is deliberately not reset; it is only meaningful once done is high.
  always_ff @(posedge clk) begin
    if (state == POOL) begin
      pool_map[f_cnt][r_cnt][c_cnt] <= win_max;
    end
  end

endmodule
